bcd_timer_ctrl: RTL and testbench
=================================

// Module: bcd_timer_ctrl
// PURPOSE
//   Run/pause/terminal-count controller for a cascaded multi-digit BCD
//   up/down counter. Sequences the count from start/stop/clear/load
//   commands and divides stepclk into count ticks with a prescaler.
//   Flags terminal count (9..9 counting up, 0..0 counting down).
//   Sits between front-panel command logic and the 7-seg digit display.
// PARAMETERS
//   NDIG      4   number of BCD digits (>=1); digit 0 is least significant
//   PRESCALE  10  stepclk cycles per count tick (>=1)
// PORTS
//   stepclk   in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-low reset
//   start     in   1        start/resume command, sampled each rising edge
//   stop      in   1        pause command
//   clear     in   1        zero the count and return to IDLE
//   load      in   1        preset the count from load_val
//   updown    in   1        direction, sampled on accepted start; 1=up 0=down
//   load_val  in   4*NDIG   preset value, BCD nibbles
//   digits    out  4*NDIG   current count, BCD nibbles
//   state     out  2        00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   running   out  1        high when state==RUN
//   done      out  1        one-cycle pulse on entry to DONE
// BEHAVIOUR
//   - reset low: digits=0, state=IDLE, running=0, done=0, prescaler=0, dir=up.
//     Takes effect immediately (no edge needed), including mid-RUN.
//   - All other outputs are registered and change on the rising stepclk edge.
//   - Command priority: clear > load > stop > start.
//     start and stop in the same cycle: stop wins.
//   - clear (any state): digits=0, prescaler=0, state=IDLE.
//   - load (IDLE/PAUSE/DONE): digits=load_val, prescaler=0, state=IDLE.
//     Ignored in RUN. Any nibble >9 is clamped to 9.
//   - start in IDLE or PAUSE: latch dir=updown.
//     If digits already equal the terminal value for dir -> DONE; else -> RUN.
//     start is ignored in RUN and DONE.
//   - stop in RUN -> PAUSE. The prescaler holds its value, so resuming keeps
//     the tick phase. stop is ignored in the other states.
//   - RUN prescaler: counts 0..PRESCALE-1, incrementing every cycle.
//     Tick on the edge where prescaler==PRESCALE-1; prescaler then wraps to 0.
//     First digit update comes PRESCALE edges after the start edge.
//   - On a tick the count steps +1 (up) or -1 (down) in BCD.
//     Up: a digit at 9 goes to 0 and carries into the next digit.
//     Down: a digit at 0 goes to 9 and borrows from the next digit.
//     The whole count steps in a single edge (no multi-cycle ripple).
//   - If a tick makes digits equal the terminal value, the same edge moves
//     state to DONE. done is high for exactly that one cycle; digits hold.
//     The count never wraps past the terminal value.
//   - updown changes while in RUN are ignored until the next accepted start.
// TESTING (NDIG=4)
//   1 P=1: load 0998, updown=1, start -> 0999, then 1000 on the next edge
//     (full carry); running=1 throughout.
//   2 P=1: load 0002, updown=0, start -> 0001, then 0000; state=11 and done=1
//     for exactly one cycle; a later start leaves state=11 and digits=0000.
//   3 P=10: clear, updown=1, start, stop 25 cycles later -> digits=0002,
//     state=10; start again -> 0003 exactly 5 edges later.
//   4 load_val=16'hA9F3 with load -> digits=16'h9993, state=00; start with
//     updown=1 -> 9994 after 10 cycles.
//   5 start and stop asserted together in IDLE -> stays IDLE, digits unchanged;
//     clear during RUN at 0123 -> 0000 and IDLE on the next edge.
//   6 reset driven low between clock edges during RUN at 0456 -> digits=0000,
//     state=00, done=0 immediately; start after reset releases -> counts up from 0000.

Source files
------------

// File: rtl/bcd_timer_ctrl_if.sv
// Command/status bundle between front-panel command logic and the BCD timer.
//   master : front panel, drives commands and the preset value, reads the status.
//   slave  : bcd_timer_ctrl, reads commands, drives digits/state/running/done.
//   start, stop, clear, load : one-bit commands, sampled on each rising stepclk
//   updown                   : count direction taken on an accepted start (1 = up)
//   load_val                 : preset value, NDIG BCD nibbles
//   digits                   : current count, NDIG BCD nibbles, digit 0 least significant
//   state                    : 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   running                  : high while state is RUN
//   done                     : one-cycle pulse on entry to DONE
interface bcd_timer_ctrl_if #(
  parameter int NDIG = 4
);
  logic              start;
  logic              stop;
  logic              clear;
  logic              load;
  logic              updown;
  logic [4*NDIG-1:0] load_val;
  logic [4*NDIG-1:0] digits;
  logic [1:0]        state;
  logic              running;
  logic              done;

  modport master (
    output start, stop, clear, load, updown, load_val,
    input  digits, state, running, done
  );

  modport slave (
    input  start, stop, clear, load, updown, load_val,
    output digits, state, running, done
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Run/pause/terminal-count controller for a cascaded NDIG-digit BCD up/down
// counter. A prescaler divides stepclk into count ticks; the whole count
// steps by one in BCD on each tick and stops at 9..9 (up) or 0..0 (down).
//   stepclk : clock, rising edge
//   reset   : asynchronous, active-low
//   bus     : bcd_timer_ctrl_if slave (commands in, digits/state/running/done out)
//
// state | meaning
// IDLE  | stopped after reset, clear or load; waits for start
// RUN   | prescaler running, count steps on every tick
// PAUSE | stopped by stop; prescaler phase kept for resume
// DONE  | terminal value reached; only clear/load leave
module bcd_timer_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 10
) (
  input  logic                 stepclk,
  input  logic                 reset,
  bcd_timer_ctrl_if.slave      bus
);

  localparam int DW = 4 * NDIG;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   digits_q;
  logic [PW-1:0]   pre_q;
  logic            dir_q;
  logic            running_q;
  logic            done_q;

  logic [DW-1:0]   step_val;
  logic [DW-1:0]   dir_term;
  logic [DW-1:0]   start_term;
  logic [DW-1:0]   load_clamped;

  function automatic logic [DW-1:0] all_nines();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // Carry ripples combinationally so the whole count steps in one edge.
  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_clamp(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  always_comb begin
    step_val     = dir_q ? bcd_inc(digits_q) : bcd_dec(digits_q);
    dir_term     = dir_q ? all_nines() : '0;
    start_term   = bus.updown ? all_nines() : '0;
    load_clamped = bcd_clamp(bus.load_val);
  end

  // A cycle that carries an accepted command does not advance the prescaler,
  // so a stop freezes the tick phase exactly where it was.
  always_ff @(posedge stepclk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      pre_q     <= '0;
      dir_q     <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear) begin
        digits_q  <= '0;
        pre_q     <= '0;
        state_q   <= S_IDLE;
        running_q <= 1'b0;
      end else if (bus.load && state_q != S_RUN) begin
        digits_q  <= load_clamped;
        pre_q     <= '0;
        state_q   <= S_IDLE;
        running_q <= 1'b0;
      end else if (bus.stop && state_q == S_RUN) begin
        state_q   <= S_PAUSE;
        running_q <= 1'b0;
      end else if (bus.start && !bus.stop &&
                   (state_q == S_IDLE || state_q == S_PAUSE)) begin
        dir_q <= bus.updown;
        if (digits_q == start_term) begin
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          running_q <= 1'b0;
        end else begin
          state_q   <= S_RUN;
          running_q <= 1'b1;
        end
      end else if (state_q == S_RUN) begin
        if (pre_q == PRE_LAST) begin
          pre_q    <= '0;
          digits_q <= step_val;
          if (step_val == dir_term) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            running_q <= 1'b0;
          end
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  assign bus.digits  = digits_q;
  assign bus.state   = state_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Testbench for bcd_timer_ctrl: two instances (PRESCALE=1 and PRESCALE=10)
// share one command stream; each has its own reference model and queue.
module tb_bcd_timer_ctrl;

  localparam int NDIG = 4;
  localparam int MAXV = 9999;
  localparam int P0   = 1;
  localparam int P1   = 10;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DONE = 3;

  logic stepclk;
  logic reset;
  logic start_r, stop_r, clear_r, load_r, updown_r;
  logic [15:0] load_val_r;

  int checks   = 0;
  int failures = 0;

  bcd_timer_ctrl_if #(.NDIG(NDIG)) bus0 ();
  bcd_timer_ctrl_if #(.NDIG(NDIG)) bus1 ();

  assign bus0.start = start_r;   assign bus1.start = start_r;
  assign bus0.stop = stop_r;     assign bus1.stop = stop_r;
  assign bus0.clear = clear_r;   assign bus1.clear = clear_r;
  assign bus0.load = load_r;     assign bus1.load = load_r;
  assign bus0.updown = updown_r; assign bus1.updown = updown_r;
  assign bus0.load_val = load_val_r;
  assign bus1.load_val = load_val_r;

  bcd_timer_ctrl #(.NDIG(NDIG), .PRESCALE(P0)) dut0 (
    .stepclk(stepclk), .reset(reset), .bus(bus0));
  bcd_timer_ctrl #(.NDIG(NDIG), .PRESCALE(P1)) dut1 (
    .stepclk(stepclk), .reset(reset), .bus(bus1));

  initial begin
    stepclk = 1'b0;
    forever #5 stepclk = ~stepclk;
  end

  // Reference model: the count is a plain integer, the phase a plain counter.
  int m_val[2], m_ph[2], m_st[2], m_dir[2], m_done[2];
  int m_pre[2] = '{P0, P1};
  logic [19:0] q0[$];
  logic [19:0] q1[$];

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(logic [15:0] lv);
    int r, mult, n;
    r = 0; mult = 1;
    for (int i = 0; i < NDIG; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      r += n * mult;
      mult *= 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_ph[k] = 0; m_st[k] = ST_IDLE; m_dir[k] = 1; m_done[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(int k, bit c_start, bit c_stop, bit c_clear,
                            bit c_load, bit c_ud, logic [15:0] lv);
    logic [19:0] e;
    m_done[k] = 0;
    if (c_clear) begin
      m_val[k] = 0; m_ph[k] = 0; m_st[k] = ST_IDLE;
    end else if (c_load && m_st[k] != ST_RUN) begin
      m_val[k] = from_bcd_clamped(lv); m_ph[k] = 0; m_st[k] = ST_IDLE;
    end else if (c_stop && m_st[k] == ST_RUN) begin
      m_st[k] = ST_PAUSE;
    end else if (c_start && !c_stop && (m_st[k] == ST_IDLE || m_st[k] == ST_PAUSE)) begin
      m_dir[k] = c_ud;
      if (m_val[k] == (c_ud ? MAXV : 0)) begin
        m_st[k] = ST_DONE; m_done[k] = 1;
      end else begin
        m_st[k] = ST_RUN;
      end
    end else if (m_st[k] == ST_RUN) begin
      m_ph[k]++;
      if (m_ph[k] == m_pre[k]) begin
        m_ph[k] = 0;
        m_val[k] = m_dir[k] ? m_val[k] + 1 : m_val[k] - 1;
        if (m_val[k] == (m_dir[k] ? MAXV : 0)) begin
          m_st[k] = ST_DONE; m_done[k] = 1;
        end
      end
    end
    e = {to_bcd(m_val[k]), 2'(m_st[k]), m_st[k] == ST_RUN, m_done[k] != 0};
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step(bit c_start, bit c_stop, bit c_clear, bit c_load,
                      bit c_ud, logic [15:0] lv);
    @(negedge stepclk);
    start_r = c_start; stop_r = c_stop; clear_r = c_clear;
    load_r = c_load; updown_r = c_ud; load_val_r = lv;
    for (int k = 0; k < 2; k++) model_step(k, c_start, c_stop, c_clear, c_load, c_ud, lv);
    @(posedge stepclk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0000);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle each instance presents a status word; compare it
  // with the oldest queued expectation.
  initial begin
    logic [19:0] e, a;
    forever begin
      @(posedge stepclk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = {bus0.digits, bus0.state, bus0.running, bus0.done};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL p1_status: got dig=%h st=%b run=%b done=%b expected dig=%h st=%b run=%b done=%b at %0t",
                   a[19:4], a[3:2], a[1], a[0], e[19:4], e[3:2], e[1], e[0], $time);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = {bus1.digits, bus1.state, bus1.running, bus1.done};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL p10_status: got dig=%h st=%b run=%b done=%b expected dig=%h st=%b run=%b done=%b at %0t",
                   a[19:4], a[3:2], a[1], a[0], e[19:4], e[3:2], e[1], e[0], $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [15:0] lv;
    reset = 1'b0;
    start_r = 0; stop_r = 0; clear_r = 0; load_r = 0; updown_r = 0; load_val_r = '0;
    model_reset();
    #12;
    chk("reset_digits", 32'(bus1.digits), 32'h0000);
    chk("reset_state", 32'(bus1.state), 32'd0);
    chk("reset_running", 32'(bus0.running), 32'd0);
    chk("reset_done", 32'(bus0.done), 32'd0);
    reset = 1'b1;

    // full carry with PRESCALE=1
    step(0, 0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0998);
    step(1, 0, 0, 0, 1, 16'h0000);
    chk("t1_start_digits", 32'(bus0.digits), 32'h0998);
    idle(1);
    chk("t1_0999", 32'(bus0.digits), 32'h0999);
    idle(1);
    chk("t1_1000", 32'(bus0.digits), 32'h1000);
    chk("t1_running", 32'(bus0.running), 32'd1);

    // count down to zero, DONE pulse, start ignored in DONE
    step(0, 0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0002);
    step(1, 0, 0, 0, 0, 16'h0000);
    idle(1);
    chk("t2_0001", 32'(bus0.digits), 32'h0001);
    idle(1);
    chk("t2_0000", 32'(bus0.digits), 32'h0000);
    chk("t2_done_state", 32'(bus0.state), 32'd3);
    chk("t2_done_pulse", 32'(bus0.done), 32'd1);
    idle(1);
    chk("t2_done_drop", 32'(bus0.done), 32'd0);
    step(1, 0, 0, 0, 1, 16'h0000);
    chk("t2_start_in_done", 32'({bus0.state, bus0.digits}), 32'({2'b11, 16'h0000}));

    // pause keeps the tick phase (PRESCALE=10)
    step(0, 0, 1, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 1, 16'h0000);
    idle(25);
    step(0, 1, 0, 0, 0, 16'h0000);
    chk("t3_pause_digits", 32'(bus1.digits), 32'h0002);
    chk("t3_pause_state", 32'(bus1.state), 32'd2);
    step(1, 0, 0, 0, 1, 16'h0000);
    idle(4);
    chk("t3_resume_4", 32'(bus1.digits), 32'h0002);
    idle(1);
    chk("t3_resume_5", 32'(bus1.digits), 32'h0003);

    // nibble clamping on load
    step(0, 0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 16'hA9F3);
    chk("t4_clamp", 32'(bus1.digits), 32'h9993);
    chk("t4_state", 32'(bus1.state), 32'd0);
    step(1, 0, 0, 0, 1, 16'h0000);
    idle(9);
    chk("t4_before_tick", 32'(bus1.digits), 32'h9993);
    idle(1);
    chk("t4_tick", 32'(bus1.digits), 32'h9994);

    // start+stop together, then clear during RUN
    step(0, 0, 1, 0, 0, 16'h0000);
    step(1, 1, 0, 0, 1, 16'h0000);
    chk("t5_startstop", 32'({bus1.state, bus1.digits}), 32'({2'b00, 16'h0000}));
    step(0, 0, 0, 1, 0, 16'h0123);
    step(1, 0, 0, 0, 1, 16'h0000);
    idle(1);
    chk("t5_run_0123", 32'({bus1.state, bus1.digits}), 32'({2'b01, 16'h0123}));
    step(0, 0, 1, 0, 0, 16'h0000);
    chk("t5_clear", 32'({bus1.state, bus1.digits}), 32'({2'b00, 16'h0000}));

    // asynchronous reset mid-RUN
    step(0, 0, 0, 1, 0, 16'h0456);
    step(1, 0, 0, 0, 1, 16'h0000);
    idle(3);
    chk("t6_pre_reset", 32'({bus1.running, bus1.digits}), 32'({1'b1, 16'h0456}));
    #1 reset = 1'b0;
    #1;
    chk("t6_reset_digits", 32'(bus1.digits), 32'h0000);
    chk("t6_reset_state", 32'(bus1.state), 32'd0);
    chk("t6_reset_done", 32'(bus1.done), 32'd0);
    chk("t6_reset_running", 32'(bus1.running), 32'd0);
    model_reset();
    reset = 1'b1;
    step(1, 0, 0, 0, 1, 16'h0000);
    idle(9);
    chk("t6_after_9", 32'(bus1.digits), 32'h0000);
    idle(1);
    chk("t6_after_10", 32'(bus1.digits), 32'h0001);

    // randomized command stream
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 2))
        0:       lv = 16'($urandom);
        1:       lv = 16'h0003;
        default: lv = 16'h9996;
      endcase
      if (r < 2)       step(0, 0, 1, 0, 0, lv);
      else if (r < 6)  step(0, 0, 0, 1, 0, lv);
      else if (r < 10) step(0, 1, 0, 0, 0, lv);
      else if (r < 12) step(1, 1, 0, 0, $urandom_range(0, 1) != 0, lv);
      else if (r < 24) step(1, 0, 0, 0, $urandom_range(0, 1) != 0, lv);
      else             step(0, 0, 0, 0, $urandom_range(0, 1) != 0, lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
